// File: rtl/mac_pkg.sv
// Shared widths and types for the 4x4 multiply-accumulate datapath.
package mac_pkg;

   localparam int A_W   = 4;
   localparam int B_W   = 4;
   localparam int P_W   = 8;
   localparam int ACC_W = 16;

   typedef logic [A_W-1:0]   operand_t;
   typedef logic [P_W-1:0]   product_t;
   typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mult_4x4.sv
// Combinational unsigned 4x4 -> 8 array multiplier built from shifted partial products.
module mult_4x4
   import mac_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   // Each set multiplier bit adds the multiplicand shifted into its column.
   always_comb begin
      p = '0;
      for (int i = 0; i < B_W; i++) begin
         if (b[i]) begin
            p = p + (product_t'(a) << i);
         end
      end
   end

endmodule

// File: rtl/mac_4x4.sv
// Three-stage pipelined unsigned MAC: capture operands, multiply, accumulate into 16 bits.
module mac_4x4
   import mac_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  a,
   input  logic [3:0]  b,
   output logic [15:0] mac_out
);

   operand_t a_q, a_d;
   operand_t b_q, b_d;
   logic     v1_q, v1_d;
   product_t p_q, p_d;
   logic     v2_q, v2_d;
   acc_t     acc_q, acc_d;
   product_t mult_p;

   mult_4x4 u_mult (
      .a (a_q),
      .b (b_q),
      .p (mult_p)
   );

   // Operands only load when qualified, so disabled-cycle data never enters the pipe.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      v1_d  = en;
      if (en) begin
         a_d = a;
         b_d = b;
      end
      p_d   = mult_p;
      v2_d  = v1_q;
      acc_d = acc_q;
      if (v2_q) begin
         acc_d = acc_q + acc_t'(p_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         v1_q  <= 1'b0;
         p_q   <= '0;
         v2_q  <= 1'b0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         v1_q  <= v1_d;
         p_q   <= p_d;
         v2_q  <= v2_d;
         acc_q <= acc_d;
      end
   end

   assign mac_out = acc_q;

endmodule

// File: tb/tb_mac_4x4.sv
// Randomised and directed bench for mac_4x4 with a queue-based scoreboard.
module tb_mac_4x4;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  a;
   logic [3:0]  b;
   logic [15:0] mac_out;

   int checkCount = 0;
   int errorCount = 0;

   int histProd[$];
   int lastReset = -1;
   int modelSum = 0;
   int expQ[$];

   mac_4x4 dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .a       (a),
      .b       (b),
      .mac_out (mac_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The reference sum is every product accepted after the latest reset whose
   // edge lies at least two edges in the past, taken modulo 2^16.
   task automatic applyStimulus(input logic r, input logic e, input int av, input int bv);
      int n;
      rst = r;
      en  = e;
      a   = 4'(av);
      b   = 4'(bv);
      @(posedge clk);
      histProd.push_back((e && !r) ? av * bv : 0);
      n = histProd.size() - 1;
      if (r) begin
         lastReset = n;
         modelSum  = 0;
      end else if (n - 2 > lastReset) begin
         modelSum = (modelSum + histProd[n-2]) % 65536;
      end
      expQ.push_back(modelSum);
      #1;
   endtask

   task automatic checkOutput(input string name, input int expected);
      @(negedge clk);
      checkCount++;
      if (int'(mac_out) != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: mac_out=%0d expected=%0d", name, mac_out, expected);
      end
   endtask

   always @(negedge clk) begin
      int expVal;
      if (expQ.size() > 0) begin
         expVal = expQ.pop_front();
         checkCount++;
         if (int'(mac_out) != expVal) begin
            errorCount++;
            $display("[TB] FAIL scoreboard @%0t: mac_out=%0d expected=%0d", $time, mac_out, expVal);
         end
      end
   end

   initial begin
      int ra, rb;
      rst = 1'b1; en = 1'b0; a = '0; b = '0;

      applyStimulus(1, 0, 0, 0);
      checkOutput("reset", 0);

      // Basic stream.
      applyStimulus(0, 1, 4, 3);
      applyStimulus(0, 1, 2, 2);
      applyStimulus(0, 1, 1, 5);
      applyStimulus(0, 1, 3, 3);
      applyStimulus(0, 1, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 9, 9);
      checkOutput("basic_stream", 30);

      // Latency of a single pair.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 5, 7);
      applyStimulus(0, 0, 0, 0);
      checkOutput("latency_k1", 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("latency_k2", 35);
      applyStimulus(0, 0, 3, 3);
      applyStimulus(0, 0, 3, 3);
      checkOutput("latency_steady", 35);

      // Enable gaps with junk operands on disabled edges.
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 15, 15);
         applyStimulus(0, 0, 9, 9);
      end
      applyStimulus(0, 0, 9, 9);
      applyStimulus(0, 0, 9, 9);
      checkOutput("enable_gaps", 900);

      // Accumulator wrap-around.
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 292; i++) applyStimulus(0, 1, 15, 15);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("wrap", 164);

      // Mid-stream reset with en high on the reset edge.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 2, 3);
      applyStimulus(0, 1, 4, 4);
      applyStimulus(1, 1, 7, 7);
      checkOutput("midreset", 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("midreset_hold", 0);
      applyStimulus(0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("after_reset", 1);

      // Exhaustive multiplier sweep through the full pipeline.
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 1, x, y);
            applyStimulus(0, 0, 15 - x, 15 - y);
            applyStimulus(0, 0, 15 - x, 15 - y);
            checkOutput($sformatf("mult_%0d_%0d", x, y), x * y);
         end
      end

      // Random traffic with occasional resets, judged by the scoreboard.
      for (int i = 0; i < 600; i++) begin
         ra = int'($urandom_range(15));
         rb = int'($urandom_range(15));
         applyStimulus(($urandom_range(49) == 0), ($urandom_range(3) != 0), ra, rb);
      end
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      @(negedge clk);
      #1;
      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL scoreboard_drain: pending=%0d expected=0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
